// File: rtl/pcs_pkg.sv
// Shared types and defaults for the PCS gearbox slip arbiter.
package pcs_pkg;

  localparam int LANE_N_DEF    = 4;
  localparam int SLIP_WAIT_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } slip_state_e;

  // Pointer width, kept at least 1 so a single-lane build still has a legal vector.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pcs_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module pcs_rr_pick #(
  parameter int LANE_N = 4,
  parameter int PW     = 2
) (
  input  logic [LANE_N-1:0] req,
  input  logic [PW-1:0]     ptr,
  output logic [LANE_N-1:0] gnt
);

  always_comb begin
    int j;
    gnt = '0;
    // Walk from the farthest candidate back to ptr so the nearest hit wins.
    for (int i = LANE_N - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % LANE_N;
      if (|(req & (LANE_N'(1) << j)))
        gnt = LANE_N'(1) << j;
    end
  end

endmodule

// File: rtl/pcs_slip_arbiter.sv
// Serialises per-lane slip requests onto one shared gearbox slip port and
// aggregates lane lock status.
module pcs_slip_arbiter
  import pcs_pkg::*;
#(
  parameter int LANE_N    = LANE_N_DEF,
  parameter int SLIP_WAIT = SLIP_WAIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              signal_ok_i,
  input  logic [LANE_N-1:0] slip_req_i,
  input  logic [LANE_N-1:0] lock_i,
  output logic [LANE_N-1:0] slip_o,
  output logic [LANE_N-1:0] slip_done_o,
  output logic              busy_o,
  output logic              all_lock_o,
  output logic              lock_lost_o
);

  localparam int PW = ptr_w(LANE_N);
  localparam int CW = $clog2(SLIP_WAIT + 1);

  slip_state_e       state, state_nxt;
  logic [LANE_N-1:0] pend, pend_nxt;
  logic [LANE_N-1:0] cur, cur_nxt;
  logic [LANE_N-1:0] slip_nxt, done_nxt;
  logic [LANE_N-1:0] req_vec, gnt;
  logic [PW-1:0]     ptr, ptr_nxt, gnt_idx;
  logic [CW-1:0]     cnt, cnt_nxt;
  logic              armed;
  logic              lock_now;

  function automatic logic [PW-1:0] oh2idx(input logic [LANE_N-1:0] oh);
    logic [PW-1:0] idx;
    idx = '0;
    for (int i = 0; i < LANE_N; i++)
      if (oh[i]) idx = PW'(i);
    return idx;
  endfunction

  assign req_vec = pend | slip_req_i;
  assign gnt_idx = oh2idx(gnt);

  pcs_rr_pick #(.LANE_N(LANE_N), .PW(PW)) u_pick (
    .req (req_vec),
    .ptr (ptr),
    .gnt (gnt)
  );

  always_comb begin
    state_nxt = state;
    pend_nxt  = req_vec;
    cur_nxt   = cur;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    slip_nxt  = '0;
    done_nxt  = '0;
    case (state)
      S_IDLE: begin
        // armed holds off the first grant until one edge after reset release.
        if (armed && |req_vec) begin
          state_nxt = S_GRANT;
          slip_nxt  = gnt;
          cur_nxt   = gnt;
          pend_nxt  = req_vec & ~gnt;
          ptr_nxt   = (gnt_idx == PW'(LANE_N - 1)) ? '0 : gnt_idx + PW'(1);
        end
      end
      S_GRANT: begin
        state_nxt = S_WAIT;
        cnt_nxt   = CW'(SLIP_WAIT - 1);
      end
      S_WAIT: begin
        if (cnt == '0) begin
          state_nxt = S_DONE;
          done_nxt  = cur;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // Loss of signal flushes everything except the fairness pointer.
    if (!signal_ok_i) begin
      state_nxt = S_IDLE;
      pend_nxt  = '0;
      cnt_nxt   = '0;
      slip_nxt  = '0;
      done_nxt  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      pend        <= '0;
      cur         <= '0;
      ptr         <= '0;
      cnt         <= '0;
      slip_o      <= '0;
      slip_done_o <= '0;
      armed       <= 1'b0;
    end else begin
      state       <= state_nxt;
      pend        <= pend_nxt;
      cur         <= cur_nxt;
      ptr         <= ptr_nxt;
      cnt         <= cnt_nxt;
      slip_o      <= slip_nxt;
      slip_done_o <= done_nxt;
      armed       <= 1'b1;
    end
  end

  assign lock_now = (&lock_i) & signal_ok_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      all_lock_o  <= 1'b0;
      lock_lost_o <= 1'b0;
    end else begin
      all_lock_o  <= lock_now;
      lock_lost_o <= all_lock_o & ~lock_now;
    end
  end

  assign busy_o = (state != S_IDLE);

endmodule

// File: tb/tb_pcs_slip_arbiter.sv
// Directed bench for pcs_slip_arbiter; slip/done pulses go through a timed scoreboard.
module tb_pcs_slip_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       signal_ok_i = 1'b1;
  logic [3:0] slip_req_i = '0;
  logic [3:0] lock_i = 4'b1111;
  logic [3:0] slip_o, slip_done_o;
  logic       busy_o, all_lock_o, lock_lost_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // One full service: GRANT(1) + WAIT(16) + DONE(1) + IDLE(1) before the next GRANT.
  localparam int PERIOD = 19;
  localparam int DONE_OFS = 17;

  typedef struct {
    bit         is_done;
    logic [3:0] lanes;
    int         cyc;
  } exp_t;
  exp_t q[$];

  pcs_slip_arbiter #(.LANE_N(4), .SLIP_WAIT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .signal_ok_i (signal_ok_i),
    .slip_req_i  (slip_req_i),
    .lock_i      (lock_i),
    .slip_o      (slip_o),
    .slip_done_o (slip_done_o),
    .busy_o      (busy_o),
    .all_lock_o  (all_lock_o),
    .lock_lost_o (lock_lost_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon_event(input bit d, input logic [3:0] v);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s: got lanes %b at cycle %0d, nothing expected",
               d ? "done" : "slip", v, cyc);
    end else begin
      e = q.pop_front();
      if (e.is_done != d || e.lanes !== v || e.cyc != cyc) begin
        errors++;
        $display("FAIL sb_event: got %s %b at cycle %0d expected %s %b at cycle %0d",
                 d ? "done" : "slip", v, cyc, e.is_done ? "done" : "slip", e.lanes, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (slip_o != 4'b0)      mon_event(1'b0, slip_o);
    if (slip_done_o != 4'b0) mon_event(1'b1, slip_done_o);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic expect_svc(input logic [3:0] lane, input int slip_cyc);
    q.push_back('{1'b0, lane, slip_cyc});
    q.push_back('{1'b1, lane, slip_cyc + DONE_OFS});
  endtask

  task automatic pulse(input logic [3:0] v);
    slip_req_i = v;
    tick();
    slip_req_i = '0;
  endtask

  initial begin
    int t;

    // Reset state, async clear and no lock_lost on the first all_lock rise.
    #2;
    chk("rst_slip", slip_o, 0);
    chk("rst_done", slip_done_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_all_lock", all_lock_o, 0);
    chk("rst_lock_lost", lock_lost_o, 0);
    tick(); tick(); tick();
    reset = 1'b0;
    tick();
    chk("rel_all_lock", all_lock_o, 1);
    chk("rel_lock_lost", lock_lost_o, 0);
    tick();
    chk("rel_lock_lost2", lock_lost_o, 0);

    // All four lanes at once from ptr=0: served 0,1,2,3.
    t = cyc;
    for (int k = 0; k < 4; k++) expect_svc(4'b0001 << k, t + 1 + PERIOD * k);
    pulse(4'b1111);
    wait_until(t + 80);

    // Single request on lane 2, busy window t+1..t+18.
    t = cyc;
    expect_svc(4'b0100, t + 1);
    pulse(4'b0100);
    chk("single_busy_first", busy_o, 1);
    wait_until(t + 18);
    chk("single_busy_last", busy_o, 1);
    tick();
    chk("single_busy_off", busy_o, 0);
    wait_until(t + 22);

    // Fairness: ptr=3, lanes 0 and 2 keep re-requesting on their done cycle.
    t = cyc;
    expect_svc(4'b0001, t + 1);
    expect_svc(4'b0100, t + 1 + PERIOD);
    expect_svc(4'b0001, t + 1 + 2 * PERIOD);
    expect_svc(4'b0100, t + 1 + 3 * PERIOD);
    pulse(4'b0101);
    wait_until(t + 18);
    pulse(4'b0001);
    wait_until(t + 37);
    pulse(4'b0100);
    wait_until(t + 80);

    // Lock aggregation.
    lock_i = 4'b0000;
    tick(); tick();
    lock_i = 4'b1111;
    chk("agg_before", all_lock_o, 0);
    tick();
    chk("agg_rise", all_lock_o, 1);
    chk("agg_rise_lost", lock_lost_o, 0);
    lock_i = 4'b1101;
    tick();
    chk("agg_fall", all_lock_o, 0);
    chk("agg_fall_lost", lock_lost_o, 1);
    tick();
    chk("agg_lost_pulse_end", lock_lost_o, 0);
    lock_i = 4'b1111;
    tick(); tick();

    // Abort in WAIT: lane 1 in service, lane 3 pending, lane 0 arrives while signal is down.
    t = cyc;
    q.push_back('{1'b0, 4'b0010, t + 1});
    pulse(4'b0010);
    wait_until(t + 3);
    pulse(4'b1000);
    wait_until(t + 5);
    signal_ok_i = 1'b0;
    tick();
    chk("abort_busy", busy_o, 0);
    chk("abort_all_lock", all_lock_o, 0);
    chk("abort_lock_lost", lock_lost_o, 1);
    pulse(4'b0001);
    chk("abort_lost_end", lock_lost_o, 0);
    signal_ok_i = 1'b1;
    wait_until(t + 35);
    chk("abort_idle", busy_o, 0);

    // ptr retained through abort (2 after lane 1): lane 3 before lane 0.
    t = cyc;
    expect_svc(4'b1000, t + 1);
    expect_svc(4'b0001, t + 1 + PERIOD);
    pulse(4'b1001);
    wait_until(t + 42);

    // Async reset mid-WAIT, then request right at release: grant one edge later, ptr back to 0.
    t = cyc;
    q.push_back('{1'b0, 4'b0100, t + 1});
    pulse(4'b0100);
    wait_until(t + 5);
    reset = 1'b1;
    #1;
    chk("areset_slip", slip_o, 0);
    chk("areset_done", slip_done_o, 0);
    chk("areset_busy", busy_o, 0);
    chk("areset_all_lock", all_lock_o, 0);
    chk("areset_lock_lost", lock_lost_o, 0);
    tick(); tick();
    reset = 1'b0;
    t = cyc;
    expect_svc(4'b0010, t + 2);
    expect_svc(4'b1000, t + 2 + PERIOD);
    pulse(4'b1010);
    wait_until(t + 45);

    chk("sb_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
